seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
Parametrised, clocked successor to the combinational ALU for the CPU datapath. It keeps the same 4-bit op encoding and adds three things: a generic WIDTH, valid/ready handshakes on input and output, and iterative signed multiply/divide in place of the combinational array units. It also adds an arithmetic-shift-right op and status flags, and sits between the operand registers and the HI/LO/Z result registers.

Parameters:
WIDTH, 32, operand width; power of two, 4 to 64.
SHW, $clog2(WIDTH), shift-amount field width; derived, not overridden.

Ports:
clk  in  1  rising-edge clock
clr_n  in  1  asynchronous active-low reset
in_valid  in  1  operands and op presented
in_ready  out  1  block can accept; transfer when in_valid & in_ready
op  in  4  0000 and, 0001 or, 0010 add, 0011 sub, 0100 shr, 0101 shl, 0110 ror, 0111 rol, 1000 mul, 1001 div, 1010 neg, 1011 not, 1100 asr, 1101-1111 illegal
a  in  WIDTH  operand A
b  in  WIDTH  operand B (sole operand for neg/not)
out_valid  out  1  result held valid
out_ready  in  1  consumer takes result when out_valid & out_ready
result  out  2*WIDTH  {hi,lo}
flag_z  out  1  result == 0
flag_n  out  1  MSB of lo (mul: MSB of hi)
flag_v  out  1  signed overflow (add/sub/neg only, else 0)
flag_err  out  1  divide by zero or illegal op

Behaviour:
- Reset: clr_n low asynchronously forces state IDLE. in_ready=1 after release; out_valid=0; result=0; all flags 0. Asserted mid-multiply/divide, it aborts the operation with no result.
- Operands and op are registered on accept. Inputs are ignored while in_ready=0.
- FSM states:
  - IDLE (in_ready=1): on accept, mul goes to MUL, div goes to DIV, every other op goes to DONE with the result computed from the captured operands.
  - MUL: radix-2 signed (Booth) shift-add, one bit per cycle, WIDTH cycles, then DONE.
  - DIV: non-restoring signed division, one quotient bit per cycle, WIDTH cycles plus 1 correction cycle, then DONE.
  - DONE: out_valid=1; result and flags stable. When out_ready, go to IDLE next cycle.
- in_ready is high only in IDLE, so there is one operation in flight and no back-to-back overlap.
- Latency, measured from accept edge k:
  - single-cycle ops: out_valid at k+1
  - mul: out_valid at k+WIDTH+1
  - div: out_valid at k+WIDTH+2
- Non-mul/div ops: hi = 0, lo = the WIDTH-bit result.
  - add/sub: modulo 2^WIDTH. flag_v is set on signed overflow.
  - neg: -b; flag_v=1 only when b = MIN (0x8000_0000 at WIDTH=32).
  - shr/shl: logical, shift amount is the full value of b; b >= WIDTH gives 0.
  - asr: arithmetic right shift; b >= WIDTH gives all sign bits.
  - ror/rol: amount = b[SHW-1:0]; amount 0 returns a unchanged.
- mul: full signed 2*WIDTH product in {hi,lo}.
- div:
  - hi = remainder, lo = quotient.
  - Quotient truncates toward zero; the remainder takes the sign of the dividend.
  - b = 0: lo = all ones, hi = a, flag_err=1, still WIDTH+1 cycles.
  - a = MIN, b = -1: lo = MIN, hi = 0, flag_err=0.
- Illegal op: result 0, flag_err=1, flag_z=1, one cycle.
- flag_z is computed over the full 2*WIDTH result.
- Holding out_ready high in DONE retires the result in one cycle. The next accept can occur on the cycle after (IDLE).

Test Plan:
1. Reset, then WIDTH=32 add a=0x7FFF_FFFF, b=1 -> out_valid at k+1; lo=0x8000_0000; flag_v=1; flag_n=1; hi=0.
2. mul a=-3, b=5 -> out_valid exactly at k+33; result=0xFFFF_FFFF_FFFF_FFF1; flag_n=1. Also mul a=0x8000_0000, b=0x8000_0000 -> 0x4000_0000_0000_0000.
3. div a=-7, b=2 -> lo=0xFFFF_FFFD (-3), hi=0xFFFF_FFFF (-1), at k+34. div a=9, b=0 -> lo=0xFFFF_FFFF, hi=9, flag_err=1.
4. ror a=0x0000_0001, b=33 -> lo=0x8000_0000. asr a=0x8000_0000, b=40 -> lo=0xFFFF_FFFF. shl a=1, b=32 -> 0 with flag_z=1.
5. Backpressure: hold out_ready=0 for 10 cycles after a result -> out_valid, result and flags stable; in_ready=0; in_valid pulses ignored. Release -> IDLE next cycle.
6. Drop clr_n at cycle 10 of a div -> out_valid=0 and result=0 immediately, in_ready=1 after release. Then op=1110 -> flag_err=1, result=0. Repeat test 2 with WIDTH=8: -3*5 -> 0xFFF1 at k+9.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with valid/ready handshakes on both sides.
// Single-cycle ops (logic, add/sub, shifts, rotates, neg, not, asr) complete
// one cycle after accept. mul runs a radix-2 Booth loop, WIDTH cycles. div runs
// a non-restoring loop on magnitudes, WIDTH cycles plus one fix-up cycle.
// Ports:
//   clk, clr_n           clock, asynchronous active-low reset
//   in_valid/in_ready    operand handshake; transfer on in_valid & in_ready
//   op, a, b             4-bit opcode and WIDTH-bit operands
//   out_valid/out_ready  result handshake; retire on out_valid & out_ready
//   result               {hi, lo}, 2*WIDTH bits
//   flag_z/n/v/err       zero, negative, signed overflow, error
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 clr_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 flag_z,
  output logic                 flag_n,
  output logic                 flag_v,
  output logic                 flag_err
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0] CNT_LAST = (SHW+1)'(WIDTH - 1);
  localparam logic [SHW:0] CNT_DIV  = (SHW+1)'(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  typedef enum logic [3:0] {
    OP_AND = 4'h0, OP_OR  = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3,
    OP_SHR = 4'h4, OP_SHL = 4'h5, OP_ROR = 4'h6, OP_ROL = 4'h7,
    OP_MUL = 4'h8, OP_DIV = 4'h9, OP_NEG = 4'hA, OP_NOT = 4'hB,
    OP_ASR = 4'hC
  } op_e;

  state_t state;
  op_e    op_sel;
  assign op_sel = op_e'(op);

  // ---------------- single-cycle datapath ----------------
  logic [SHW-1:0]     amt;
  logic               shift_big;
  logic [2*WIDTH-1:0] rot_r, rot_l;
  logic [WIDTH-1:0]   sum, diff, neg_b, asr_r;
  logic [WIDTH-1:0]   alu_lo;
  logic               alu_v, alu_err;

  assign amt       = b[SHW-1:0];
  // WIDTH is a power of two, so b >= WIDTH exactly when an upper bit is set.
  assign shift_big = |b[WIDTH-1:SHW];
  // Shifting the doubled word yields rotates in one half and the plain
  // logical shift in the other half.
  assign rot_r     = {a, a} >> amt;
  assign rot_l     = {a, a} << amt;
  assign sum       = a + b;
  assign diff      = a - b;
  assign neg_b     = '0 - b;
  assign asr_r     = $signed(a) >>> amt;

  always_comb begin
    alu_lo  = '0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    case (op_sel)
      OP_AND: alu_lo = a & b;
      OP_OR:  alu_lo = a | b;
      OP_ADD: begin
        alu_lo = sum;
        alu_v  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_lo = diff;
        alu_v  = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SHR: alu_lo = shift_big ? '0 : rot_r[2*WIDTH-1:WIDTH];
      OP_SHL: alu_lo = shift_big ? '0 : rot_l[WIDTH-1:0];
      OP_ROR: alu_lo = rot_r[WIDTH-1:0];
      OP_ROL: alu_lo = rot_l[2*WIDTH-1:WIDTH];
      OP_NEG: begin
        alu_lo = neg_b;
        alu_v  = b[WIDTH-1] && (b[WIDTH-2:0] == '0);
      end
      OP_NOT: alu_lo = ~b;
      OP_ASR: alu_lo = shift_big ? {WIDTH{a[WIDTH-1]}} : asr_r;
      OP_MUL, OP_DIV: alu_lo = '0;
      default: alu_err = 1'b1;
    endcase
  end

  // ---------------- iterative multiply (Booth radix-2) ----------------
  logic [SHW:0]       cnt;
  logic [WIDTH:0]     m_acc, m_ext, m_sum, m_acc_nx;
  logic [WIDTH-1:0]   m_q, m_q_nx, m_mcand;
  logic               m_qm1;
  logic [2*WIDTH-1:0] mul_prod;

  // Accumulator carries one guard bit so subtracting MIN cannot overflow.
  assign m_ext = {m_mcand[WIDTH-1], m_mcand};

  always_comb begin
    m_sum = m_acc;
    case ({m_q[0], m_qm1})
      2'b10:   m_sum = m_acc - m_ext;
      2'b01:   m_sum = m_acc + m_ext;
      default: m_sum = m_acc;
    endcase
    m_acc_nx = {m_sum[WIDTH], m_sum[WIDTH:1]};
    m_q_nx   = {m_sum[0], m_q[WIDTH-1:1]};
    mul_prod = {m_acc_nx[WIDTH-1:0], m_q_nx};
  end

  // ---------------- iterative divide (non-restoring) ----------------
  // Runs on magnitudes; the fix-up cycle restores a negative remainder and
  // applies signs (quotient toward zero, remainder follows the dividend).
  logic [WIDTH+1:0]   d_rem, d_shift, d_next, dv_ext;
  logic [WIDTH-1:0]   d_q, d_q_nx, d_dvsr, d_a, rem_fix, q_out, r_out;
  logic               d_sa, d_sb, d_zero;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] div_res;

  assign a_mag  = a[WIDTH-1] ? ('0 - a) : a;
  assign b_mag  = b[WIDTH-1] ? ('0 - b) : b;
  assign dv_ext = {2'b00, d_dvsr};

  always_comb begin
    d_shift = {d_rem[WIDTH:0], d_q[WIDTH-1]};
    d_next  = d_rem[WIDTH+1] ? (d_shift + dv_ext) : (d_shift - dv_ext);
    d_q_nx  = {d_q[WIDTH-2:0], ~d_next[WIDTH+1]};
    rem_fix = d_rem[WIDTH+1] ? (d_rem[WIDTH-1:0] + d_dvsr) : d_rem[WIDTH-1:0];
    q_out   = (d_sa ^ d_sb) ? ('0 - d_q) : d_q;
    r_out   = d_sa ? ('0 - rem_fix) : rem_fix;
    div_res = d_zero ? {d_a, {WIDTH{1'b1}}} : {r_out, q_out};
  end

  // ---------------- control ----------------
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      flag_v    <= 1'b0;
      flag_err  <= 1'b0;
      cnt       <= '0;
      m_acc     <= '0;
      m_q       <= '0;
      m_qm1     <= 1'b0;
      m_mcand   <= '0;
      d_rem     <= '0;
      d_q       <= '0;
      d_dvsr    <= '0;
      d_sa      <= 1'b0;
      d_sb      <= 1'b0;
      d_zero    <= 1'b0;
      d_a       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            cnt      <= '0;
            case (op_sel)
              OP_MUL: begin
                m_acc   <= '0;
                m_q     <= b;
                m_qm1   <= 1'b0;
                m_mcand <= a;
                state   <= S_MUL;
              end
              OP_DIV: begin
                d_rem  <= '0;
                d_q    <= a_mag;
                d_dvsr <= b_mag;
                d_sa   <= a[WIDTH-1];
                d_sb   <= b[WIDTH-1];
                d_zero <= (b == '0);
                d_a    <= a;
                state  <= S_DIV;
              end
              default: begin
                result    <= {{WIDTH{1'b0}}, alu_lo};
                flag_z    <= (alu_lo == '0);
                flag_n    <= alu_lo[WIDTH-1];
                flag_v    <= alu_v;
                flag_err  <= alu_err;
                out_valid <= 1'b1;
                state     <= S_DONE;
              end
            endcase
          end
        end
        S_MUL: begin
          m_acc <= m_acc_nx;
          m_q   <= m_q_nx;
          m_qm1 <= m_q[0];
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            result    <= mul_prod;
            flag_z    <= (mul_prod == '0);
            flag_n    <= mul_prod[2*WIDTH-1];
            flag_v    <= 1'b0;
            flag_err  <= 1'b0;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DIV: begin
          if (cnt != CNT_DIV) begin
            d_rem <= d_next;
            d_q   <= d_q_nx;
            cnt   <= cnt + 1'b1;
          end else begin
            result    <= div_res;
            flag_z    <= (div_res == '0);
            flag_n    <= div_res[WIDTH-1];
            flag_v    <= 1'b0;
            flag_err  <= d_zero;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: a WIDTH=32 and a WIDTH=8 instance checked against an
// arithmetic reference model (signed longint math) with random and directed ops.
module tb_seq_alu;

  logic        clk   = 1'b0;
  logic        clr_n = 1'b0;
  logic [3:0]  op_in = '0;
  logic [31:0] a_in  = '0;
  logic [31:0] b_in  = '0;
  logic        iv32 = 1'b0, iv8 = 1'b0, out_ready = 1'b0;

  logic        ir32, ov32, z32, n32, v32, e32;
  logic [63:0] res32;
  logic        ir8, ov8, z8, n8, v8, e8;
  logic [15:0] res8;

  int checks = 0;
  int failures = 0;
  int sel_w = 32;
  logic pending = 1'b0;
  logic [63:0] exp_res = '0;
  logic [3:0]  exp_flags = '0;

  logic        cur_ir, cur_ov;
  logic [3:0]  cur_flags;
  logic [63:0] cur_res;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(32)) u32 (
    .clk(clk), .clr_n(clr_n), .in_valid(iv32), .in_ready(ir32), .op(op_in),
    .a(a_in), .b(b_in), .out_valid(ov32), .out_ready(out_ready), .result(res32),
    .flag_z(z32), .flag_n(n32), .flag_v(v32), .flag_err(e32)
  );

  seq_alu #(.WIDTH(8)) u8 (
    .clk(clk), .clr_n(clr_n), .in_valid(iv8), .in_ready(ir8), .op(op_in),
    .a(a_in[7:0]), .b(b_in[7:0]), .out_valid(ov8), .out_ready(out_ready), .result(res8),
    .flag_z(z8), .flag_n(n8), .flag_v(v8), .flag_err(e8)
  );

  always_comb begin
    if (sel_w == 8) begin
      cur_ir = ir8; cur_ov = ov8; cur_res = {48'b0, res8}; cur_flags = {z8, n8, v8, e8};
    end else begin
      cur_ir = ir32; cur_ov = ov32; cur_res = res32; cur_flags = {z32, n32, v32, e32};
    end
  end

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s w=%0d actual=%h expected=%h t=%0t", name, sel_w, act, exp, $time);
    end
  endfunction

  // Reference model: flags returned as {z, n, v, err}.
  function automatic void model(input int w, input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b, output logic [63:0] res, output logic [3:0] fl);
    logic [63:0] mask, am, bm, lo, hi;
    longint sa, sb, t, mn, mx;
    int sh;
    logic v, err, n;
    mask = (64'd1 << w) - 64'd1;
    am = {32'b0, a} & mask;
    bm = {32'b0, b} & mask;
    sa = am[w-1] ? longint'(am) - (longint'(1) << w) : longint'(am);
    sb = bm[w-1] ? longint'(bm) - (longint'(1) << w) : longint'(bm);
    mn = -(longint'(1) << (w - 1));
    mx = (longint'(1) << (w - 1)) - 1;
    lo = '0; hi = '0; v = 1'b0; err = 1'b0; res = '0;
    case (op)
      4'd0: lo = am & bm;
      4'd1: lo = am | bm;
      4'd2: begin t = sa + sb; lo = 64'(t) & mask; v = (t > mx) || (t < mn); end
      4'd3: begin t = sa - sb; lo = 64'(t) & mask; v = (t > mx) || (t < mn); end
      4'd4: lo = (bm >= 64'(w)) ? 64'd0 : (am >> bm);
      4'd5: lo = (bm >= 64'(w)) ? 64'd0 : ((am << bm) & mask);
      4'd6: begin
        sh = int'(bm % 64'(w)); lo = am;
        repeat (sh) lo = ((lo >> 1) | ((lo & 64'd1) << (w - 1))) & mask;
      end
      4'd7: begin
        sh = int'(bm % 64'(w)); lo = am;
        repeat (sh) lo = ((lo << 1) | (lo >> (w - 1))) & mask;
      end
      4'd8: begin
        t = sa * sb;
        res = (w == 32) ? 64'(t) : (64'(t) & ((64'd1 << (2 * w)) - 64'd1));
      end
      4'd9: begin
        if (sb == 0) begin lo = mask; hi = am; err = 1'b1; end
        else begin
          t = sa / sb; lo = 64'(t) & mask;
          t = sa % sb; hi = 64'(t) & mask;
        end
      end
      4'd10: begin t = -sb; lo = 64'(t) & mask; v = (sb == mn); end
      4'd11: lo = ~bm & mask;
      4'd12: begin
        if (bm >= 64'(w)) lo = (sa < 0) ? mask : 64'd0;
        else lo = 64'(sa >>> bm) & mask;
      end
      default: err = 1'b1;
    endcase
    if (op != 4'd8) res = (hi << w) | lo;
    n = (op == 4'd8) ? res[2*w-1] : res[w-1];
    fl = {(res == 64'd0), n, v, err};
  endfunction

  task automatic pin(input string name, input int w, input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [63:0] er, input logic [3:0] ef);
    logic [63:0] r;
    logic [3:0]  f;
    model(w, op, a, b, r, f);
    chk({"pin_res_", name}, r, er);
    chk({"pin_flags_", name}, 64'(f), 64'(ef));
  endtask

  task automatic set_iv(input int w, input logic val);
    if (w == 8) iv8 = val; else iv32 = val;
  endtask

  // Runs one transaction on the selected instance; called at a negedge.
  task automatic run_op(input int w, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int bp);
    int n, lat, exp_lat;
    logic [63:0] r;
    logic [3:0]  f;
    model(w, op, a, b, r, f);
    sel_w = w;
    exp_lat = (op == 4'd8) ? w + 1 : (op == 4'd9) ? w + 2 : 1;
    n = 0;
    while (!cur_ir && n < 100) begin @(negedge clk); n++; end
    chk("in_ready_idle", 64'(cur_ir), 64'd1);
    op_in = op; a_in = a; b_in = b;
    exp_res = r; exp_flags = f;
    set_iv(w, 1'b1);
    @(posedge clk);
    #1;
    set_iv(w, 1'b0);
    pending = 1'b1;
    a_in = $urandom; b_in = $urandom; op_in = 4'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!cur_ov) set_iv(w, 1'($urandom_range(0, 1)));
    end while (!cur_ov && lat < 100);
    chk("latency", 64'(lat), 64'(exp_lat));
    repeat (bp) begin
      @(negedge clk);
      set_iv(w, 1'($urandom_range(0, 1)));
      a_in = $urandom; b_in = $urandom;
    end
    set_iv(w, 1'b0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    pending = 1'b0;
    @(negedge clk);
    chk("retire_out_valid", 64'(cur_ov), 64'd0);
    chk("retire_in_ready", 64'(cur_ir), 64'd1);
  endtask

  function automatic logic [31:0] rnd(input int w);
    logic [31:0] m;
    m = (w == 32) ? 32'hFFFF_FFFF : 32'((64'd1 << w) - 64'd1);
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1 << (w - 1);
      2: return m;
      3: return m >> 1;
      4: return 32'($urandom_range(0, 2 * w));
      default: return $urandom & m;
    endcase
  endfunction

  // Compare process: every cycle a result is presented it must match the model.
  always @(negedge clk) begin
    if (pending && cur_ov) begin
      chk("result", cur_res, exp_res);
      chk("flags_znve", 64'(cur_flags), 64'(exp_flags));
      chk("in_ready_busy", 64'(cur_ir), 64'd0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_hold_ov32", 64'(ov32), 64'd0);
    clr_n = 1'b1;
    @(negedge clk);
    chk("rst_ir32", 64'(ir32), 64'd1);
    chk("rst_ov32", 64'(ov32), 64'd0);
    chk("rst_res32", res32, 64'd0);
    chk("rst_flags32", 64'({z32, n32, v32, e32}), 64'd0);
    chk("rst_ir8", 64'(ir8), 64'd1);
    chk("rst_ov8", 64'(ov8), 64'd0);
    chk("rst_res8", 64'(res8), 64'd0);
    chk("rst_flags8", 64'({z8, n8, v8, e8}), 64'd0);

    // Hand-computed anchors for the model.
    pin("add_ovf", 32, 4'd2, 32'h7FFF_FFFF, 32'd1, 64'h0000_0000_8000_0000, 4'b0110);
    pin("mul_m3x5", 32, 4'd8, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 4'b0100);
    pin("mul_minmin", 32, 4'd8, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 4'b0000);
    pin("div_m7d2", 32, 4'd9, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 4'b0100);
    pin("div_by0", 32, 4'd9, 32'd9, 32'd0, 64'h0000_0009_FFFF_FFFF, 4'b0101);
    pin("div_minm1", 32, 4'd9, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 4'b0100);
    pin("ror33", 32, 4'd6, 32'd1, 32'd33, 64'h0000_0000_8000_0000, 4'b0100);
    pin("asr40", 32, 4'd12, 32'h8000_0000, 32'd40, 64'h0000_0000_FFFF_FFFF, 4'b0100);
    pin("shl32", 32, 4'd5, 32'd1, 32'd32, 64'd0, 4'b1000);
    pin("neg_min", 32, 4'd10, 32'd0, 32'h8000_0000, 64'h0000_0000_8000_0000, 4'b0110);
    pin("illegal", 32, 4'd14, 32'd5, 32'd6, 64'd0, 4'b1001);
    pin("mul8", 8, 4'd8, 32'hFD, 32'd5, 64'h0000_0000_0000_FFF1, 4'b0100);

    // Directed transactions.
    run_op(32, 4'd2, 32'h7FFF_FFFF, 32'd1, 0);
    run_op(32, 4'd8, 32'hFFFF_FFFD, 32'd5, 0);
    run_op(32, 4'd8, 32'h8000_0000, 32'h8000_0000, 0);
    run_op(32, 4'd9, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(32, 4'd9, 32'd9, 32'd0, 0);
    run_op(32, 4'd9, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(32, 4'd6, 32'd1, 32'd33, 0);
    run_op(32, 4'd7, 32'h8000_0001, 32'd0, 0);
    run_op(32, 4'd12, 32'h8000_0000, 32'd40, 0);
    run_op(32, 4'd5, 32'd1, 32'd32, 0);
    run_op(32, 4'd10, 32'd0, 32'h8000_0000, 0);
    run_op(32, 4'd3, 32'h8000_0000, 32'd1, 10);

    // Reset in the middle of a divide.
    sel_w = 32;
    run_op(32, 4'd2, 32'd5, 32'd6, 0);
    op_in = 4'd9; a_in = 32'd100; b_in = 32'd7; iv32 = 1'b1;
    @(posedge clk);
    #1 iv32 = 1'b0;
    repeat (10) @(negedge clk);
    #2 clr_n = 1'b0;
    #1;
    chk("abort_out_valid", 64'(ov32), 64'd0);
    chk("abort_result", res32, 64'd0);
    chk("abort_flags", 64'({z32, n32, v32, e32}), 64'd0);
    @(negedge clk);
    #2 clr_n = 1'b1;
    @(negedge clk);
    chk("abort_in_ready", 64'(ir32), 64'd1);
    chk("abort_idle_ov", 64'(ov32), 64'd0);

    run_op(32, 4'd14, 32'd3, 32'd4, 0);
    run_op(8, 4'd8, 32'hFD, 32'd5, 0);
    run_op(8, 4'd9, 32'h80, 32'hFF, 0);

    for (int i = 0; i < 60; i++)
      run_op(32, 4'($urandom_range(0, 15)), rnd(32), rnd(32), int'($urandom_range(0, 3)));
    for (int i = 0; i < 40; i++)
      run_op(8, 4'($urandom_range(0, 15)), rnd(8), rnd(8), int'($urandom_range(0, 3)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
